pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. It drives the enable and flush inputs of PC, IF_ID, ID_EX and EX_MEM. It resolves three hazard sources:
- load-use data hazards, via a one-cycle bubble;
- taken branches resolved in MEM, via a three-stage flush;
- multi-cycle data-memory accesses, via a full freeze with timeout.

It also keeps a saturating stall-cycle counter and a sticky error flag.

---
 rtl/pipeline_hazard_ctrl_if.sv | 43 ++++
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard-detection inputs and pipeline-control outputs that pass
// between the 5-stage datapath (master) and the hazard controller (slave).
// The datapath side drives register fields and memory/branch status; the
// controller side drives stage enables, flushes, error and stall statistics.
// All signals are level-based and sampled every cycle; there is no
// valid/ready handshake because the controller reacts combinationally to the
// current inputs and its registered state, with no added latency.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       ex_rt;
  logic             ex_MemRead;
  logic             mem_branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             err;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state_dbg;

  modport master (
    output id_rs, id_rt, ex_rt, ex_MemRead, mem_branch_taken, mem_req, mem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en,
    input  if_id_flush, id_ex_flush, ex_mem_flush,
    input  err, stall_cnt, state_dbg
  );

  modport slave (
    input  id_rs, id_rt, ex_rt, ex_MemRead, mem_branch_taken, mem_req, mem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en,
    output if_id_flush, id_ex_flush, ex_mem_flush,
    output err, stall_cnt, state_dbg
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline.
// Resolves load-use hazards with a single bubble, taken branches (resolved in
// MEM) with a three-stage flush, and multi-cycle data-memory accesses with a
// full pipeline freeze bounded by MAX_WAIT cycles, after which the controller
// locks in ERROR until reset. A saturating counter records every cycle in
// which the PC was held.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0]       MAX_WAIT_L = 8'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [7:0]       wait_cnt, wait_nxt;
  logic [CNT_W-1:0] stall_q;
  logic             err_q, err_nxt;

  logic lu;
  logic run_pc_en, run_if_id_en, run_id_ex_en, run_ex_mem_en;
  logic run_if_id_flush, run_id_ex_flush, run_ex_mem_flush;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush;

  // Branch / load-use / normal-flow controls, shared by RUN and by MEM_WAIT release.
  always_comb begin
    lu = hz.ex_MemRead && (hz.ex_rt != 5'd0) &&
         ((hz.ex_rt == hz.id_rs) || (hz.ex_rt == hz.id_rt));
    run_pc_en        = 1'b1;
    run_if_id_en     = 1'b1;
    run_id_ex_en     = 1'b1;
    run_ex_mem_en    = 1'b1;
    run_if_id_flush  = 1'b0;
    run_id_ex_flush  = 1'b0;
    run_ex_mem_flush = 1'b0;
    if (hz.mem_branch_taken) begin
      // The bubble a load-use stall would insert is flushed anyway, so LU is ignored.
      run_if_id_flush  = 1'b1;
      run_id_ex_flush  = 1'b1;
      run_ex_mem_flush = 1'b1;
    end else if (lu) begin
      run_pc_en       = 1'b0;
      run_if_id_en    = 1'b0;
      run_id_ex_flush = 1'b1;
    end
  end

  // Next-state and output decode; everything idles at zero unless a state grants it.
  always_comb begin
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    err_nxt      = err_q;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (hz.mem_req && !hz.mem_ready) begin
            state_nxt = MEM_WAIT;
            wait_nxt  = 8'd1;
          end else begin
            pc_en        = run_pc_en;
            if_id_en     = run_if_id_en;
            id_ex_en     = run_id_ex_en;
            ex_mem_en    = run_ex_mem_en;
            if_id_flush  = run_if_id_flush;
            id_ex_flush  = run_id_ex_flush;
            ex_mem_flush = run_ex_mem_flush;
          end
        end
        MEM_WAIT: begin
          // The frozen pipeline holds the request, so mem_req is not looked at here.
          if (hz.mem_ready) begin
            state_nxt    = RUN;
            wait_nxt     = 8'd0;
            pc_en        = run_pc_en;
            if_id_en     = run_if_id_en;
            id_ex_en     = run_id_ex_en;
            ex_mem_en    = run_ex_mem_en;
            if_id_flush  = run_if_id_flush;
            id_ex_flush  = run_id_ex_flush;
            ex_mem_flush = run_ex_mem_flush;
          end else if (wait_cnt == MAX_WAIT_L) begin
            state_nxt = ERROR;
            err_nxt   = 1'b1;
          end else begin
            wait_nxt = wait_cnt + 8'd1;
          end
        end
        ERROR: begin
          err_nxt = 1'b1;
        end
        default: begin
          state_nxt = RUN;
          wait_nxt  = 8'd0;
        end
      endcase
    end
  end

  // State, wait counter and sticky error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      err_q    <= err_nxt;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!pc_en && (stall_q != CNT_MAX)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.if_id_en     = if_id_en;
  assign hz.id_ex_en     = id_ex_en;
  assign hz.ex_mem_en    = ex_mem_en;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_flush = ex_mem_flush;
  assign hz.err          = err_q;
  assign hz.stall_cnt    = stall_q;
  assign hz.state_dbg    = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios
// followed by randomized traffic, checked against a cycle-level model of the
// hazard rules through an expected-value queue.
module tb_pipeline_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 3;
  localparam int SAT      = (1 << CNT_W) - 1;
  localparam int EW       = 8 + CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  // reference model: memory-wait progress, lock-up and stall statistics
  bit m_waiting = 0;
  int m_waited  = 0;
  bit m_dead    = 0;
  int m_stalls  = 0;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_flush}
  function automatic logic [6:0] flow_ctl(input logic br, input logic lu);
    if (br)      return 7'b1111_111;
    else if (lu) return 7'b0011_010;
    else         return 7'b1111_000;
  endfunction

  // driver: apply one cycle of inputs and predict the outputs for that cycle
  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] exrt, input logic mr, input logic br,
                       input logic req, input logic rdy);
    logic lu;
    logic [6:0] ctl;
    @(posedge clk);
    #1;
    rst                 = r;
    hz.id_rs            = rs;
    hz.id_rt            = rt;
    hz.ex_rt            = exrt;
    hz.ex_MemRead       = mr;
    hz.mem_branch_taken = br;
    hz.mem_req          = req;
    hz.mem_ready        = rdy;
    lu = mr && (exrt != 5'd0) && (exrt == rs || exrt == rt);
    if (r || m_dead)    ctl = 7'b0;
    else if (m_waiting) ctl = rdy ? flow_ctl(br, lu) : 7'b0;
    else                ctl = (req && !rdy) ? 7'b0 : flow_ctl(br, lu);
    if (r) exp_q.push_back('0);
    else   exp_q.push_back({ctl, m_dead, CNT_W'(m_stalls)});
    // effect of the coming clock edge
    if (r) begin
      m_waiting = 0; m_waited = 0; m_dead = 0; m_stalls = 0;
    end else begin
      if (!m_dead) begin
        if (m_waiting) begin
          if (rdy) m_waiting = 0;
          else if (m_waited == MAX_WAIT) m_dead = 1;
          else m_waited++;
        end else if (req && !rdy) begin
          m_waiting = 1;
          m_waited  = 1;
        end
      end
      if (!ctl[6] && m_stalls < SAT) m_stalls++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);
  endtask

  // monitor: compare live outputs mid-cycle against the oldest prediction
  always @(negedge clk) begin
    logic [EW-1:0] got, e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en,
             hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.err, hz.stall_cnt};
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL vec%0d ctl/err/cnt got=%b exp=%b at %0t", n_vec, got, e, $time);
      end
    end
  end

  initial begin
    hz.id_rs = '0; hz.id_rt = '0; hz.ex_rt = '0; hz.ex_MemRead = 0;
    hz.mem_branch_taken = 0; hz.mem_req = 0; hz.mem_ready = 0;

    // reset state
    drive(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    drive(1, 5'd8, 5'd0, 5'd8, 1, 0, 1, 0);
    idle(2);

    // load-use: one bubble, then the bubble removes the hazard
    drive(0, 5'd8, 5'd4, 5'd8, 1, 0, 0, 0);
    drive(0, 5'd8, 5'd4, 5'd0, 0, 0, 0, 0);
    // load into $zero never stalls; rt match also detected
    drive(0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
    drive(0, 5'd3, 5'd9, 5'd9, 1, 0, 0, 0);
    idle(1);

    // branch taken together with load-use: flush wins, no stall
    drive(0, 5'd8, 5'd4, 5'd8, 1, 1, 0, 0);
    idle(1);

    // memory wait: three cycles low then release
    drive(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    drive(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    drive(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    drive(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    drive(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 1);
    idle(1);

    // release coinciding with a taken branch
    drive(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    drive(0, 5'd1, 5'd2, 5'd3, 0, 1, 1, 1);
    idle(1);

    // timeout into sticky error, then reset out of it
    drive(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) drive(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    drive(0, 5'd8, 5'd4, 5'd8, 1, 1, 0, 1);
    drive(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    idle(2);

    // reset asserted between edges while waiting on memory
    drive(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    drive(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    drive(1, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    idle(2);

    // saturation: ten consecutive load-use stalls
    drive(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 5'd5, 5'd6, 5'd5, 1, 0, 0, 0);
    idle(1);

    // randomized traffic with narrow register fields to provoke matches
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 39) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0));
    end

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain leftover=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
